// File: rtl/io_arbiter.sv
// io_arbiter: shares one byte-stream io unit between two requesters (r0, r1).
//
// Purpose: accepts IN/OUT operations from two requesters, issues the winner
// onto the io unit's ope/ds_val/dd port for one cycle, waits for io_busy to
// drop, then returns the IN writeback to the requester that issued it.
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   rX_ope/rX_ds_val/rX_dd       requester X operation, OUT data, IN dest addr
//   rX_ack                       one-cycle pulse: request accepted
//   rX_busy                      requester X has an operation outstanding
//   rX_wb_addr/rX_wb_val         writeback pulse (addr 0 = none), value held
//   io_ope/io_ds_val/io_dd       issue port to the io unit
//   io_reg_addr/io_reg_dd_val    writeback from the io unit
//   io_busy                      io unit busy
//
// Configuration macro: IO_ARB_FIXED_PRIO_EN -- when defined r0 always wins a
// tie; otherwise ties are resolved round-robin.

module io_arbiter (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  r0_ope,
  input  logic [31:0] r0_ds_val,
  input  logic [5:0]  r0_dd,
  output logic        r0_ack,
  output logic        r0_busy,
  output logic [5:0]  r0_wb_addr,
  output logic [31:0] r0_wb_val,
  input  logic [5:0]  r1_ope,
  input  logic [31:0] r1_ds_val,
  input  logic [5:0]  r1_dd,
  output logic        r1_ack,
  output logic        r1_busy,
  output logic [5:0]  r1_wb_addr,
  output logic [31:0] r1_wb_val,
  output logic [5:0]  io_ope,
  output logic [31:0] io_ds_val,
  output logic [5:0]  io_dd,
  input  logic [5:0]  io_reg_addr,
  input  logic [31:0] io_reg_dd_val,
  input  logic        io_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            r_state, w_state_d;
  logic              r_owner, w_owner_d;
  logic              r_last, w_last_d;
  logic [5:0]        r_io_ope, w_io_ope_d;
  logic [31:0]       r_io_ds_val, w_io_ds_val_d;
  logic [5:0]        r_io_dd, w_io_dd_d;
  logic [1:0]        r_ack, w_ack_d;
  logic [1:0]        r_busy, w_busy_d;
  logic [1:0][5:0]   r_wb_addr, w_wb_addr_d;
  logic [1:0][31:0]  r_wb_val, w_wb_val_d;

  logic w_req0, w_req1, w_grant1;

  assign w_req0 = |r0_ope;
  assign w_req1 = |r1_ope;

`ifdef IO_ARB_FIXED_PRIO_EN
  assign w_grant1 = w_req1 & ~w_req0;
`else
  // On a tie, r1 wins only if r0 was granted last.
  assign w_grant1 = w_req1 & (~w_req0 | ~r_last);
`endif

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_last_d      = r_last;
    w_io_ope_d    = r_io_ope;
    w_io_ds_val_d = r_io_ds_val;
    w_io_dd_d     = r_io_dd;
    w_ack_d       = '0;
    w_busy_d      = r_busy;
    w_wb_addr_d   = '0;
    w_wb_val_d    = r_wb_val;
    unique case (r_state)
      StIdle: begin
        w_io_ope_d = '0;
        if (w_req0 || w_req1) begin
          w_owner_d          = w_grant1;
          w_last_d           = w_grant1;
          w_io_ope_d         = w_grant1 ? r1_ope    : r0_ope;
          w_io_ds_val_d      = w_grant1 ? r1_ds_val : r0_ds_val;
          w_io_dd_d          = w_grant1 ? r1_dd     : r0_dd;
          w_ack_d[w_grant1]  = 1'b1;
          w_busy_d[w_grant1] = 1'b1;
          w_state_d          = StIssue;
        end
      end
      StIssue: begin
        // io samples the op at the edge closing this cycle.
        w_io_ope_d = '0;
        w_state_d  = StWait;
      end
      StWait: begin
        if (!io_busy) begin
          w_wb_addr_d[r_owner] = io_reg_addr;
          w_wb_val_d[r_owner]  = io_reg_dd_val;
          w_busy_d[r_owner]    = 1'b0;
          w_state_d            = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_io_ope    <= '0;
      r_io_ds_val <= '0;
      r_io_dd     <= '0;
      r_ack       <= '0;
      r_busy      <= '0;
      r_wb_addr   <= '0;
      r_wb_val    <= '0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_last      <= w_last_d;
      r_io_ope    <= w_io_ope_d;
      r_io_ds_val <= w_io_ds_val_d;
      r_io_dd     <= w_io_dd_d;
      r_ack       <= w_ack_d;
      r_busy      <= w_busy_d;
      r_wb_addr   <= w_wb_addr_d;
      r_wb_val    <= w_wb_val_d;
    end
  end

  assign r0_ack     = r_ack[0];
  assign r1_ack     = r_ack[1];
  assign r0_busy    = r_busy[0];
  assign r1_busy    = r_busy[1];
  assign r0_wb_addr = r_wb_addr[0];
  assign r1_wb_addr = r_wb_addr[1];
  assign r0_wb_val  = r_wb_val[0];
  assign r1_wb_val  = r_wb_val[1];
  assign io_ope     = r_io_ope;
  assign io_ds_val  = r_io_ds_val;
  assign io_dd      = r_io_dd;

endmodule
